key_pixel_pipeline: RTL

//  Pipelined, parametrised per-pixel colour generator for the keyboard display.

---
 rtl/key_pixel_if.sv | 37 +++
 rtl/key_pixel_pipeline.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/key_pixel_if.sv
// Pixel-side bus of the key pixel pipeline: coordinates, key/glyph tags, glyph ROM port, VGA RGB.
interface key_pixel_if #(
    parameter int NUM_KEYS = 14,
    parameter int GLYPH_W  = 8,
    parameter int ROM_AW   = 11
);
    localparam int KW = $clog2(NUM_KEYS + 1);

    logic                frame_start;
    logic                pix_valid;
    logic [9:0]          DrawX;
    logic [9:0]          DrawY;
    logic [KW-1:0]       key_idx;
    logic                key_black;
    logic [3:0]          glyph_sel;
    logic [9:0]          glyph_x0;
    logic [9:0]          glyph_y0;
    logic [NUM_KEYS-1:0] key_on;
    logic [ROM_AW-1:0]   rom_addr;
    logic [GLYPH_W-1:0]  rom_data;
    logic [7:0]          VGA_R;
    logic [7:0]          VGA_G;
    logic [7:0]          VGA_B;
    logic                out_valid;

    modport master (
        output frame_start, pix_valid, DrawX, DrawY, key_idx, key_black,
               glyph_sel, glyph_x0, glyph_y0, key_on, rom_data,
        input  rom_addr, VGA_R, VGA_G, VGA_B, out_valid
    );

    modport slave (
        input  frame_start, pix_valid, DrawX, DrawY, key_idx, key_black,
               glyph_sel, glyph_x0, glyph_y0, key_on, rom_data,
        output rom_addr, VGA_R, VGA_G, VGA_B, out_valid
    );
endinterface

// File: rtl/key_pixel_pipeline.sv
// Two-stage per-pixel colour generator for the keyboard display, with per-key fading press highlight.
// Optional macro GRADIENT_BG_EN: background blue ramps down with DrawX[9:3].

module key_fade_level #(
    parameter int FADE_BITS = 4,
    parameter int FADE_STEP = 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 frame_start,
    input  logic                 key_on,
    output logic [FADE_BITS-1:0] level
);
    localparam logic [FADE_BITS-1:0] LMAX = {FADE_BITS{1'b1}};

    // A sounding key pins the level at max, even on a frame_start cycle.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)            level <= '0;
        else if (key_on)      level <= LMAX;
        else if (frame_start) level <= (int'(level) > FADE_STEP) ? level - FADE_BITS'(FADE_STEP) : '0;
    end
endmodule

module key_pixel_pipeline #(
    parameter int NUM_KEYS  = 14,
    parameter int GLYPH_W   = 8,
    parameter int GLYPH_H   = 16,
    parameter int ROM_AW    = 11,
    parameter int FADE_BITS = 4,
    parameter int FADE_STEP = 1
) (
    input  logic      Clk,
    input  logic      Reset,
    key_pixel_if.slave pif
);
    localparam int KW     = $clog2(NUM_KEYS + 1);
    localparam int XW     = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
    localparam int SHIFT  = 8 - FADE_BITS;
    localparam int STAGES = 2;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    logic [NUM_KEYS-1:0][FADE_BITS-1:0] level;

    generate
        for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
            key_fade_level #(.FADE_BITS(FADE_BITS), .FADE_STEP(FADE_STEP)) u_fade (
                .Clk        (Clk),
                .Reset      (Reset),
                .frame_start(pif.frame_start),
                .key_on     (pif.key_on[k]),
                .level      (level[k])
            );
        end
    endgenerate

    // Stage 0: glyph-relative coordinates; negative offsets wrap large and miss the box.
    logic [9:0]           rel_x, rel_y;
    logic                 glyph_hit;
    logic [FADE_BITS-1:0] key_level;

    assign rel_x     = pif.DrawX - pif.glyph_x0;
    assign rel_y     = pif.DrawY - pif.glyph_y0;
    assign glyph_hit = (pif.glyph_sel != 4'd0) && (rel_x < 10'(GLYPH_W)) && (rel_y < 10'(GLYPH_H));
    assign pif.rom_addr = ROM_AW'((32'(pif.glyph_sel) - 32'd1) * 32'(GLYPH_H) + 32'(rel_y));

    always_comb begin
        key_level = '0;
        for (int k = 0; k < NUM_KEYS; k++)
            if (pif.key_idx == KW'(k + 1)) key_level = level[k];
    end

    // Stage 1 registers
    logic [STAGES:1]      vld_pipe;
    logic [KW-1:0]        s1_key_idx;
    logic                 s1_black;
    logic                 s1_hit;
    logic [XW-1:0]        s1_rel_x;
    logic [FADE_BITS-1:0] s1_level;
`ifdef GRADIENT_BG_EN
    logic [6:0]           s1_dx;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            vld_pipe   <= '0;
            s1_key_idx <= '0;
            s1_black   <= 1'b0;
            s1_hit     <= 1'b0;
            s1_rel_x   <= '0;
            s1_level   <= '0;
`ifdef GRADIENT_BG_EN
            s1_dx      <= '0;
`endif
        end else begin
            vld_pipe   <= {vld_pipe[STAGES-1:1], pif.pix_valid};
            s1_key_idx <= pif.key_idx;
            s1_black   <= pif.key_black;
            s1_hit     <= glyph_hit;
            s1_rel_x   <= rel_x[XW-1:0];
            s1_level   <= key_level;
`ifdef GRADIENT_BG_EN
            s1_dx      <= pif.DrawX[9:3];
`endif
        end
    end

    // Stage 2: ROM row arrives now; leftmost glyph pixel is the MSB.
    logic [XW-1:0] px_idx;
    logic          glyph_px;
    logic          key_hit;
    logic [7:0]    shade;
    rgb_t          bg, colour, rgb_q;

    assign px_idx   = XW'(GLYPH_W - 1) - s1_rel_x;
    assign glyph_px = s1_hit && pif.rom_data[px_idx];
    assign key_hit  = (s1_key_idx != '0) && (s1_key_idx <= KW'(NUM_KEYS));
    assign shade    = 8'(s1_level) << SHIFT;
`ifdef GRADIENT_BG_EN
    assign bg = '{r: 8'h3f, g: 8'h00, b: 8'h7f - {1'b0, s1_dx}};
`else
    assign bg = '{r: 8'h3f, g: 8'h00, b: 8'h7f};
`endif

    always_comb begin
        colour = bg;
        if (!vld_pipe[1])           colour = '{r: 8'h00, g: 8'h00, b: 8'h00};
        else if (glyph_px)          colour = '{r: 8'h00, g: 8'hff, b: 8'h00};
        else if (key_hit && !s1_black) colour = '{r: 8'hff - shade, g: 8'hff, b: 8'hff - shade};
        else if (key_hit)           colour = '{r: 8'h00, g: shade, b: 8'h00};
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) rgb_q <= '0;
        else       rgb_q <= colour;
    end

    assign pif.VGA_R     = rgb_q.r;
    assign pif.VGA_G     = rgb_q.g;
    assign pif.VGA_B     = rgb_q.b;
    assign pif.out_valid = vld_pipe[STAGES];
endmodule
